sram_req_adapter: RTL and testbench
===================================

Name: sram_req_adapter

Overview:
- Request/response front-end for the 32x128 single-port RW OpenRAM macro.
- Converts a valid/ready request stream (reads, full writes, byte-masked writes) into registered csb0/web0/addr0/din0 pin activity, and captures dout0 on the exact posedge where it is valid.
- Implements byte masks by read-modify-write (RMW), because the macro has no write mask.
- Read data returns in order through a response FIFO with credit-based backpressure.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- ADDR_WIDTH, 7, word address width.
- RSP_DEPTH, 4, response FIFO entries; minimum 2.

Ports:
- clk0 in 1: clock, shared with the macro.
- rst_n in 1: asynchronous active-low reset.
- req_valid in 1: request valid.
- req_ready out 1: request accepted when valid&&ready at posedge.
- req_we in 1: 1 = write, 0 = read.
- req_addr in ADDR_WIDTH: word address.
- req_wdata in DATA_WIDTH: write data.
- req_wmask in DATA_WIDTH/8: byte enables; bit i covers bits [8i+7:8i].
- rsp_valid out 1: read data available.
- rsp_ready in 1: consumer accepts response.
- rsp_rdata out DATA_WIDTH: read data, FIFO head.
- sram_csb0 out 1: to macro csb0, active low.
- sram_web0 out 1: to macro web0, active low.
- sram_addr0 out ADDR_WIDTH: to macro addr0.
- sram_din0 out DATA_WIDTH: to macro din0.
- sram_dout0 in DATA_WIDTH: from macro dout0.
- busy out 1: FSM not IDLE, or any read/RMW in flight, or FIFO non-empty.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0, req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0.
  - State: FSM=IDLE, FIFO empty, in-flight tags cleared.
  - Reset released mid-operation drops all pending work. An SRAM write sampled before reset may or may not land; the content of that word is undefined.
- Pin timing: all sram_* outputs are flops. A command accepted at posedge k drives the pins in cycle k..k+1; the macro samples them at posedge k+1. Read data is captured from sram_dout0 at posedge k+2 and at no other edge, because dout0 is X after posedge+hold. In any cycle with no command: csb0=1, web0=1, addr0/din0 hold their last value.
- Capture tagging: a 2-stage tag pipe records NONE, READ or RMW per issued slot and selects the destination at capture.
- Credit: reads_outstanding = FIFO count + READ tags in flight. req_ready = (state==IDLE) && (reads_outstanding < RSP_DEPTH). This holds for every request type; req_ready has no combinational dependence on req_valid or req_we.
- Request decode on accept:
  - Read: issue csb0=0, web0=1. Result is pushed to the FIFO at posedge k+2.
  - Write with wmask all ones: issue csb0=0, web0=0, din0=wdata. No response. Next request can be accepted at k+1 (full throughput).
  - Write with wmask all zero: no-op. No pin activity, no response.
  - Write with partial wmask: enter RMW.
- RMW FSM:
  - IDLE -> RMW_RD (accept at k; read pins driven for k..k+1).
  - RMW_RD -> RMW_WAIT (posedge k+1; pins idle).
  - RMW_WAIT -> RMW_WR (posedge k+2): capture dout0; merged = (dout & ~bytemask) | (wdata & bytemask); drive write pins.
  - RMW_WR -> IDLE (posedge k+3; macro samples the write).
  - req_ready=0 from k+1 through the end of cycle k+3; the next accept is possible at posedge k+4.
  - Captured RMW data never enters the FIFO.
- Ordering and hazards: commands issue strictly in acceptance order. The macro writes on the negedge of its sample cycle, so a read accepted the cycle after a write to the same address returns the new data; no forwarding is required. An RMW started while earlier reads are in flight captures in its own tagged slot, with no collision.
- FIFO:
  - rsp_valid = !empty.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle are allowed when full.
  - Overflow is impossible by credit. Overflow is an assertion target, not handled logic.

Test Plan:
- Reset check: with rst_n=0 mid-read -> csb0=1, web0=1, rsp_valid=0, busy=0 immediately. After release, FIFO is empty and no stale response appears.
- Write then read, rsp_ready=1: write addr 0x05 data 0xDEADBEEF mask 0xF at posedge 1, read 0x05 at posedge 2 -> rsp_valid at posedge 4 with rsp_rdata=0xDEADBEEF. req_ready stays high throughout.
- Back-to-back reads: 8 reads of addr 0..7 with rsp_ready=1 -> one response per cycle starting 2 cycles after the first accept, in address order, no bubbles.
- Backpressure: rsp_ready=0, issue 6 reads -> exactly 4 accepted, then req_ready=0. Raise rsp_ready -> 4 in-order responses drain, and the remaining 2 are accepted.
- RMW: mem[0x10]=0x11223344, then write 0xAABBCCDD mask 0b0101 -> read of 0x10 returns 0x11BB33DD. req_ready is low for 3 cycles after the accept, and the RMW produces no rsp_valid of its own.
- Zero mask and full mask: write mask 0x0 to 0x20 -> no csb0 pulse, and the word is unchanged on readback. Write mask 0xF -> a single csb0/web0 pulse and no RMW read cycle.

Source files
------------

// File: rtl/sram_req_adapter.sv
// sram_req_adapter: valid/ready front-end for a single-port RW SRAM macro.
// Byte masks become read-modify-write; read data returns in order through a credited FIFO.
module sram_req_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                    clk0,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    sram_csb0,
    output logic                    sram_web0,
    output logic [ADDR_WIDTH-1:0]   sram_addr0,
    output logic [DATA_WIDTH-1:0]   sram_din0,
    input  logic [DATA_WIDTH-1:0]   sram_dout0,
    output logic                    busy
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 3);

    typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WAIT, RMW_WR} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_READ, TAG_RMW} tag_t;

    state_t                state_q, state_d;
    tag_t                  tag1_q, tag1_d, tag2_q;
    logic                  csb_q, csb_d, web_q, web_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d, wdata_q, wdata_d, bmask, merged;
    logic [NB-1:0]         mask_q, mask_d;
    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q, count_d, reads_out;
    logic                  accept, issue, zero_wr, full_wr, part_wr, wr_issue, push, pop;

    for (genvar b = 0; b < NB; b++) begin : g_bmask
        assign bmask[8*b +: 8] = {8{mask_q[b]}};
    end

    // Credit counts reads already queued plus those still in the capture pipe.
    assign reads_out = count_q + CW'(tag1_q == TAG_READ) + CW'(tag2_q == TAG_READ);
    assign req_ready = rst_n && (state_q == IDLE) && (reads_out < CW'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign zero_wr   = req_we && ~|req_wmask;
    assign full_wr   = req_we && &req_wmask;
    assign part_wr   = req_we && !zero_wr && !full_wr;
    assign issue     = accept && !zero_wr;
    assign wr_issue  = tag2_q == TAG_RMW;
    assign merged    = (sram_dout0 & ~bmask) | (wdata_q & bmask);
    assign push      = tag2_q == TAG_READ;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = count_q != '0;
    assign rsp_rdata = rsp_valid ? fifo_q[rptr_q] : '0;
    assign busy      = (state_q != IDLE) || (tag1_q != TAG_NONE) || (tag2_q != TAG_NONE) || rsp_valid;
    assign sram_csb0  = csb_q;
    assign sram_web0  = web_q;
    assign sram_addr0 = addr_q;
    assign sram_din0  = din_q;

    always_comb begin
        state_d = (state_q == IDLE)     ? ((accept && part_wr) ? RMW_RD : IDLE) :
                  (state_q == RMW_RD)   ? RMW_WAIT :
                  (state_q == RMW_WAIT) ? RMW_WR : IDLE;
        tag1_d  = (accept && !req_we) ? TAG_READ : (accept && part_wr) ? TAG_RMW : TAG_NONE;
        csb_d   = !(issue || wr_issue);
        web_d   = !((accept && full_wr) || wr_issue);
        addr_d  = issue ? req_addr : addr_q;
        din_d   = wr_issue ? merged : (accept && full_wr) ? req_wdata : din_q;
        wdata_d = (accept && part_wr) ? req_wdata : wdata_q;
        mask_d  = (accept && part_wr) ? req_wmask : mask_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tag1_q  <= TAG_NONE;
            tag2_q  <= TAG_NONE;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            addr_q  <= '0;
            din_q   <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tag1_q  <= tag1_d;
            tag2_q  <= tag1_q;
            csb_q   <= csb_d;
            web_q   <= web_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            if (push) wptr_q <= (wptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            if (pop) rptr_q <= (rptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk0) begin
        if (push) fifo_q[wptr_q] <= sram_dout0;
    end

    assert property (@(posedge clk0) disable iff (!rst_n) !(push && !pop && count_q == CW'(RSP_DEPTH)));
endmodule

// File: tb/tb_sram_req_adapter.sv
// tb_sram_req_adapter: directed scoreboard bench with a behavioural single-port SRAM model
// whose dout is only valid from the read negedge until just after the following posedge.
module tb_sram_req_adapter;
    logic        clk0 = 1'b0, rst_n = 1'b1, req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        req_ready, rsp_valid, sram_csb0, sram_web0, busy;
    logic [6:0]  sram_addr0;
    logic [31:0] rsp_rdata, sram_din0;
    logic [31:0] sram_dout0 = '0;
    int          checks = 0, failures = 0, cyc = 0, acc_cyc = 0, wait_n = 0, rsp_cnt = 0, last_rsp_cyc = 0;
    int          a0, b0;
    logic [31:0] mem [128];
    logic [127:0] written = '0;
    logic [31:0] ref_mem [128];
    logic [31:0] exp_q [$];
    logic        m_csb = 1'b1, m_web = 1'b1;
    logic [6:0]  m_addr = '0;
    logic [31:0] m_din = '0;

    sram_req_adapter dut (
        .clk0(clk0), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0), .busy(busy)
    );

    always #5 clk0 = ~clk0;
    always @(posedge clk0) cyc++;

    function automatic logic [31:0] init_val(input int a);
        return 32'hA500_0000 | (32'(a) * 32'h0001_0101);
    endfunction

    // Macro model: sample pins at posedge, act at the following negedge, garble dout after hold.
    always @(posedge clk0) begin
        m_csb = sram_csb0;
        m_web = sram_web0;
        m_addr = sram_addr0;
        m_din = sram_din0;
        #1 sram_dout0 = 32'hBAD0_0BAD ^ 32'(cyc);
        @(negedge clk0);
        if (!m_csb && !m_web) begin
            mem[m_addr] = m_din;
            written[m_addr] = 1'b1;
        end else if (!m_csb) begin
            sram_dout0 = written[m_addr] ? mem[m_addr] : init_val(int'(m_addr));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk0) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("rsp_data", rsp_rdata, exp_q.pop_front());
            rsp_cnt++;
            last_rsp_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    // Must be entered just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic we, input logic [6:0] a, input logic [31:0] d, input logic [3:0] m);
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        req_wmask = m;
        wait_n = 0;
        do begin
            @(negedge clk0);
            wait_n++;
        end while (!req_ready && wait_n < 50);
        chk("accept", req_ready, 1);
        step();
        acc_cyc = cyc;
        req_valid = 1'b0;
        if (we) begin
            for (int i = 0; i < 4; i++) if (m[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
        end else begin
            exp_q.push_back(ref_mem[a]);
        end
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk0);
            n++;
        end while (exp_q.size() != 0 && n < 100);
        chk("drain", exp_q.size(), 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        #1 rst_n = 1'b0;
        #2;
        chk("reset_pins", {sram_csb0, sram_web0, sram_addr0, sram_din0}, {2'b11, 7'd0, 32'd0});
        chk("reset_ctl", {req_ready, rsp_valid, busy, rsp_rdata}, {3'b000, 32'd0});
        @(negedge clk0);
        rst_n = 1'b1;
        step();
        // write then read of the same word
        rsp_ready = 1'b1;
        send(1'b1, 7'h05, 32'hDEADBEEF, 4'hF);
        send(1'b0, 7'h05, 32'h0, 4'h0);
        chk("wr_rd_no_stall", wait_n, 1);
        @(negedge clk0) chk("rd_lat0", rsp_valid, 0);
        @(negedge clk0) chk("rd_lat1", rsp_valid, 0);
        @(negedge clk0) chk("rd_lat2", {rsp_valid, rsp_rdata}, {1'b1, 32'hDEADBEEF});
        drain();
        // back-to-back reads
        b0 = rsp_cnt;
        a0 = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 7'(i), 32'h0, 4'h0);
            if (i == 0) a0 = acc_cyc;
        end
        chk("b2b_accept_span", acc_cyc - a0, 7);
        drain();
        chk("b2b_rsp_count", rsp_cnt - b0, 8);
        chk("b2b_last_rsp", last_rsp_cyc - a0, 9);
        // backpressure: four credits, then stall with a fifth read pending
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 7'(48 + i), 32'h0, 4'h0);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 7'h34;
        @(negedge clk0) chk("bp_ready_low", req_ready, 0);
        repeat (3) @(negedge clk0);
        chk("bp_stalled", {req_ready, rsp_valid, busy}, 3'b011);
        step();
        rsp_ready = 1'b1;
        send(1'b0, 7'h34, 32'h0, 4'h0);
        chk("bp_resume_wait", wait_n, 2);
        send(1'b0, 7'h35, 32'h0, 4'h0);
        drain();
        // read-modify-write
        send(1'b1, 7'h10, 32'h11223344, 4'hF);
        send(1'b1, 7'h10, 32'hAABBCCDD, 4'b0101);
        @(negedge clk0) chk("rmw_rd_cycle", {req_ready, sram_csb0, sram_web0, rsp_valid}, 4'b0010);
        @(negedge clk0) chk("rmw_wait_cycle", {req_ready, sram_csb0, sram_web0, rsp_valid}, 4'b0110);
        @(negedge clk0) chk("rmw_wr_cycle", {req_ready, sram_csb0, sram_web0, rsp_valid, sram_din0}, {4'b0000, 32'h11BB33DD});
        @(negedge clk0) chk("rmw_done", {req_ready, sram_csb0, sram_web0, rsp_valid}, 4'b1110);
        step();
        send(1'b0, 7'h10, 32'h0, 4'h0);
        drain();
        // RMW issued right behind a read still in flight
        send(1'b0, 7'h07, 32'h0, 4'h0);
        send(1'b1, 7'h08, 32'h01020304, 4'b1000);
        send(1'b0, 7'h08, 32'h0, 4'h0);
        chk("rmw_after_rd_wait", wait_n, 4);
        drain();
        // zero mask is a no-op
        send(1'b1, 7'h20, 32'hFFFFFFFF, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk0);
            chk("zero_no_csb", {sram_csb0, req_ready}, 2'b11);
        end
        step();
        send(1'b0, 7'h20, 32'h0, 4'h0);
        drain();
        // full mask is a single write pulse
        send(1'b1, 7'h20, 32'h5A5AA5A5, 4'hF);
        @(negedge clk0) chk("full_pins", {sram_csb0, sram_web0, sram_addr0, sram_din0}, {2'b00, 7'h20, 32'h5A5AA5A5});
        @(negedge clk0) chk("full_no_rmw", {sram_csb0, req_ready}, 2'b11);
        step();
        send(1'b0, 7'h20, 32'h0, 4'h0);
        drain();
        // reset during a read drops it
        send(1'b0, 7'h05, 32'h0, 4'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {sram_csb0, sram_web0, rsp_valid, busy, req_ready}, 5'b11000);
        exp_q.delete();
        @(negedge clk0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk0);
        chk("rst_after", {rsp_valid, busy}, 2'b00);
        step();
        send(1'b0, 7'h05, 32'h0, 4'h0);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
